decode_cycle: RTL and testbench
===============================

Name: decode_cycle

Overview:
- Second pipeline stage, directly downstream of the fetch stage.
- Consumes the instruction word (InstrD), PCD and PCPlus4D, and decodes the 20-bit instruction into control signals.
- Reads and writes a 16x20-bit register file and sign-extends immediates.
- Registers everything into the decode/execute pipeline register that feeds the execute stage. Writeback results return here through the RegWriteW/RdW/ResultW port.

Parameters:
- XLEN, 20, datapath and instruction width
- NREG, 16, register-file depth; x0 reads as zero

Ports:
- clk  in  1  stage clock
- rst  in  1  asynchronous reset, active-high
- InstrD  in  20  instruction from fetch register
- PCD  in  20  PC of InstrD
- PCPlus4D  in  20  PCD+4
- RegWriteW  in  1  writeback enable
- RdW  in  4  writeback destination
- ResultW  in  20  writeback data
- FlushE  in  1  hazard flush: insert bubble into execute
- StallE  in  1  hold execute register (FlushE has priority)
- RegWriteE  out  1  registered control
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- MemWriteE  out  1
- JumpE  out  1
- BranchE  out  1
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- ALUSrcE  out  1  1 = immediate operand
- RD1E, RD2E  out  20  register operands
- ImmExtE  out  20  sign-extended immediate
- PCE, PCPlus4E  out  20
- RdE, Rs1E, Rs2E  out  4  register indices for hazard unit

Behaviour:
- Instruction fields:
  - op = [19:16], rd = [15:12], rs1 = [11:8], rs2 = [7:4], funct = [3:0].
  - Opcodes: 0 NOP, 1 R-ALU (ALUControl = funct[2:0]; funct[2:0] 110/111 decode as add), 2 I-ALU addi, 3 LOAD, 4 STORE, 5 BEQ, 6 JAL. Opcodes 7–15 are undefined and decode as NOP.
- Immediates, all sign-extended to 20 bits:
  - I-type / LOAD: imm = InstrD[7:0].
  - STORE: imm = {InstrD[15:12], InstrD[3:0]}.
  - BEQ: imm = {InstrD[15:12], InstrD[3:0]} << 2.
  - JAL: imm = InstrD[11:0] << 2.
- Control per opcode:
  - R-ALU: RegWrite=1, ALUSrc=0.
  - I-ALU: RegWrite=1, ALUSrc=1, add.
  - LOAD: RegWrite=1, ALUSrc=1, ResultSrc=01, add.
  - STORE: MemWrite=1, ALUSrc=1, add.
  - BEQ: Branch=1, sub.
  - JAL: Jump=1, RegWrite=1, ResultSrc=10.
  - NOP: all controls zero.
- Register file:
  - Two combinational read ports.
  - Write on posedge clk when RegWriteW and RdW != 0.
  - Write-first bypass: if a read index equals RdW and the write is enabled with RdW != 0, the read returns ResultW in the same cycle.
  - Reads of x0 always return 0; writes to x0 are ignored.
- Decode/execute register, on posedge clk:
  - Priority is rst > FlushE > StallE > load.
  - FlushE clears RegWriteE, MemWriteE, JumpE, BranchE, ResultSrcE and ALUControlE to 0. Data fields are don't-care and are cleared to 0.
  - StallE holds all fields unchanged.
  - Latency: decode inputs appear on the E outputs 1 cycle later.
- Reset (asynchronous, rst=1): all E outputs are 0 and all 16 registers are 0, immediately and held while rst=1. Deassertion takes effect at the next posedge.
- Reset mid-operation: the in-flight decoded instruction is discarded, with no partial register write. A writeback coinciding with the reset edge is dropped.
- Simultaneous FlushE and StallE: flush wins.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- With the macro defined:
  - Adds output IllegalE (1 bit), registered like the other controls.
  - Set when op is 7–15, or when op=1 with funct[3]=1.
  - All other controls for that instruction are forced to 0.
  - IllegalE is cleared by flush and by reset.
- Without the macro: the port is absent and those encodings decode silently as NOP.

Decomposition:
- Package decode_pkg:
  - XLEN
  - Register index width
  - Opcode enum (OP_NOP..OP_JAL)
  - ALU control localparams
  - ResultSrc encodings
  - Immediate-type enum (IMM_I, IMM_S, IMM_B, IMM_J)
- Sub-module register_file: 2 read ports, 1 write port, x0 hardwired to zero, write-first bypass, asynchronous reset.
- Control decode and immediate extension stay in decode_cycle as combinational blocks.

Test Plan:
- Reset: assert rst mid-stream with InstrD=0x12340 → all E outputs 0 asynchronously, before the next edge; registers read 0 afterwards.
- Writeback bypass: RegWriteW=1, RdW=3, ResultW=0xABCDE with InstrD=0x15330 (add x5,x3,x3) → next cycle RD1E=RD2E=0xABCDE, RdE=5, RegWriteE=1, ALUControlE=000.
- x0 protection: write RdW=0, ResultW=0xFFFFF, then decode rs1=0 → RD1E=0.
- Immediates:
  - InstrD=0x221FF (addi x2,x1,-1) → ImmExtE=0xFFFFF, ALUSrcE=1.
  - BEQ InstrD=0x5F128 → ImmExtE = sext(0xF8)<<2 = 0xFFFE0, BranchE=1, ALUControlE=001.
- Flush/stall: issue a LOAD with FlushE=1 → RegWriteE=0, ResultSrcE=00. Then StallE=1 for 2 cycles with a new InstrD → E outputs unchanged. FlushE and StallE both high → bubble.
- Illegal (DECODE_ILLEGAL_TRAP_EN defined): InstrD=0x91234 → IllegalE=1, RegWriteE=0. With the macro undefined → all controls 0.

Source files
------------

// File: rtl/decode_cycle_pkg.sv
// Shared types and encodings for the decode stage: opcodes, ALU/result-source
// encodings, immediate kinds and the decode/execute pipeline register layout.
package decode_pkg;

  localparam int XLEN   = 20;
  localparam int NREG   = 16;
  localparam int REG_AW = 4;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_RALU  = 4'd1,
    OP_IALU  = 4'd2,
    OP_LOAD  = 4'd3,
    OP_STORE = 4'd4,
    OP_BEQ   = 4'd5,
    OP_JAL   = 4'd6
  } opcode_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_type_e;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
  } ctrl_t;

  typedef struct packed {
    ctrl_t              ctrl;
    logic [XLEN-1:0]    rd1;
    logic [XLEN-1:0]    rd2;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc4;
    logic [REG_AW-1:0]  rd;
    logic [REG_AW-1:0]  rs1;
    logic [REG_AW-1:0]  rs2;
  } de_reg_t;

  // Only the low 16 instruction bits ever carry immediate data.
  function automatic logic [XLEN-1:0] imm_extend(input logic [15:0] instr,
                                                 input imm_type_e   kind);
    logic [XLEN-1:0] imm;
    case (kind)
      IMM_I:   imm = {{(XLEN-8){instr[7]}}, instr[7:0]};
      IMM_S:   imm = {{(XLEN-8){instr[15]}}, instr[15:12], instr[3:0]};
      IMM_B:   imm = {{(XLEN-10){instr[15]}}, instr[15:12], instr[3:0], 2'b00};
      IMM_J:   imm = {{(XLEN-14){instr[11]}}, instr[11:0], 2'b00};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_cycle_register_file.sv
// 16 x XLEN register file: two combinational read ports with write-first
// bypass, one write port, x0 hardwired to zero, asynchronous clear.
module register_file
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] i_rs1_addr,
  input  logic [REG_AW-1:0] i_rs2_addr,
  output logic [XLEN-1:0]   o_rd1,
  output logic [XLEN-1:0]   o_rd2,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_wr_addr,
  input  logic [XLEN-1:0]   i_wr_data
);

  logic [XLEN-1:0]   r_regs [NREG];
  logic              w_wr_en;
  logic [REG_AW-1:0] w_raddr [2];
  logic [XLEN-1:0]   w_rdata [2];

  assign w_wr_en = i_we && (i_wr_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  assign w_raddr[0] = i_rs1_addr;
  assign w_raddr[1] = i_rs2_addr;

  // Same-cycle writeback is forwarded so decode never sees a stale operand.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      assign w_rdata[gi] = (w_raddr[gi] == '0)                      ? '0 :
                           (w_wr_en && (w_raddr[gi] == i_wr_addr)) ? i_wr_data :
                                                                     r_regs[w_raddr[gi]];
    end
  endgenerate

  assign o_rd1 = w_rdata[0];
  assign o_rd2 = w_rdata[1];

endmodule

// File: rtl/decode_cycle.sv
// Decode stage: instruction decode, register read, immediate extension and the
// decode/execute register. Define DECODE_ILLEGAL_TRAP_EN to add IllegalE.
module decode_cycle
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RdW,
  input  logic [XLEN-1:0]   ResultW,
  input  logic              FlushE,
  input  logic              StallE,
  output logic              RegWriteE,
  output logic [1:0]        ResultSrcE,
  output logic              MemWriteE,
  output logic              JumpE,
  output logic              BranchE,
  output logic [2:0]        ALUControlE,
  output logic              ALUSrcE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [REG_AW-1:0] RdE,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic              IllegalE
`endif
);

  logic [3:0]        w_op;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic [3:0]        w_funct;
  ctrl_t             w_ctrl;
  imm_type_e         w_imm_type;
  logic [XLEN-1:0]   w_imm;
  logic [XLEN-1:0]   w_rd1;
  logic [XLEN-1:0]   w_rd2;
  de_reg_t           w_de_next;
  de_reg_t           r_de;

  assign {w_op, w_rd, w_rs1, w_rs2, w_funct} = InstrD;

  register_file u_register_file (
    .clk        (clk),
    .rst        (rst),
    .i_rs1_addr (w_rs1),
    .i_rs2_addr (w_rs2),
    .o_rd1      (w_rd1),
    .o_rd2      (w_rd2),
    .i_we       (RegWriteW),
    .i_wr_addr  (RdW),
    .i_wr_data  (ResultW)
  );

  // Undefined opcodes and R-ALU with funct[3] set fall through with all controls zero.
  always_comb begin
    w_ctrl     = '0;
    w_imm_type = IMM_I;
    case (w_op)
      OP_RALU: begin
        if (!w_funct[3]) begin
          w_ctrl.reg_write   = 1'b1;
          w_ctrl.alu_control = (w_funct[2:1] == 2'b11) ? ALU_ADD : w_funct[2:0];
        end
      end
      OP_IALU: begin
        w_ctrl.reg_write   = 1'b1;
        w_ctrl.alu_src     = 1'b1;
        w_ctrl.alu_control = ALU_ADD;
        w_imm_type         = IMM_I;
      end
      OP_LOAD: begin
        w_ctrl.reg_write   = 1'b1;
        w_ctrl.alu_src     = 1'b1;
        w_ctrl.result_src  = RES_MEM;
        w_ctrl.alu_control = ALU_ADD;
        w_imm_type         = IMM_I;
      end
      OP_STORE: begin
        w_ctrl.mem_write   = 1'b1;
        w_ctrl.alu_src     = 1'b1;
        w_ctrl.alu_control = ALU_ADD;
        w_imm_type         = IMM_S;
      end
      OP_BEQ: begin
        w_ctrl.branch      = 1'b1;
        w_ctrl.alu_control = ALU_SUB;
        w_imm_type         = IMM_B;
      end
      OP_JAL: begin
        w_ctrl.jump        = 1'b1;
        w_ctrl.reg_write   = 1'b1;
        w_ctrl.result_src  = RES_PC4;
        w_imm_type         = IMM_J;
      end
      default: begin
        w_ctrl = '0;
      end
    endcase
  end

  assign w_imm = imm_extend(InstrD[15:0], w_imm_type);

  always_comb begin
    w_de_next      = '0;
    w_de_next.ctrl = w_ctrl;
    w_de_next.rd1  = w_rd1;
    w_de_next.rd2  = w_rd2;
    w_de_next.imm  = w_imm;
    w_de_next.pc   = PCD;
    w_de_next.pc4  = PCPlus4D;
    w_de_next.rd   = w_rd;
    w_de_next.rs1  = w_rs1;
    w_de_next.rs2  = w_rs2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_de <= '0;
    end else if (FlushE) begin
      r_de <= '0;
    end else if (!StallE) begin
      r_de <= w_de_next;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic w_illegal;
  logic r_illegal;

  assign w_illegal = (w_op > 4'd6) || ((w_op == OP_RALU) && w_funct[3]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else if (FlushE) begin
      r_illegal <= 1'b0;
    end else if (!StallE) begin
      r_illegal <= w_illegal;
    end
  end

  assign IllegalE = r_illegal;
`endif

  assign RegWriteE   = r_de.ctrl.reg_write;
  assign ResultSrcE  = r_de.ctrl.result_src;
  assign MemWriteE   = r_de.ctrl.mem_write;
  assign JumpE       = r_de.ctrl.jump;
  assign BranchE     = r_de.ctrl.branch;
  assign ALUControlE = r_de.ctrl.alu_control;
  assign ALUSrcE     = r_de.ctrl.alu_src;
  assign RD1E        = r_de.rd1;
  assign RD2E        = r_de.rd2;
  assign ImmExtE     = r_de.imm;
  assign PCE         = r_de.pc;
  assign PCPlus4E    = r_de.pc4;
  assign RdE         = r_de.rd;
  assign Rs1E        = r_de.rs1;
  assign Rs2E        = r_de.rs2;

endmodule

// File: tb/tb_decode_cycle.sv
// Scoreboard bench for decode_cycle: a reference decoder and register model
// push expected E-stage contents per cycle; outputs are popped and compared.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE, StallE;
  logic [3:0]  RdW;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [19:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [3:0]  RdE, Rs1E, Rs2E;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        IllegalE;
`endif

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .FlushE(FlushE), .StallE(StallE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E)
`ifdef DECODE_ILLEGAL_TRAP_EN
    , .IllegalE(IllegalE)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic [2:0]  alu_control;
    logic        alu_src;
    logic        illegal;
    logic        imm_chk;
    logic [19:0] rd1, rd2, imm, pc, pc4;
    logic [3:0]  rd, rs1, rs2;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        last_exp;
  logic [19:0] mregs [16];
  logic [19:0] pc_ctr = 20'h00100;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] model_read(input logic [3:0] a, input logic we,
                                              input logic [3:0] rdw, input logic [19:0] resw);
    if (a == 4'd0) return 20'd0;
    if (we && rdw == a) return resw;
    return mregs[a];
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e = '0;
    e.imm_chk = 1'b1;
    return e;
  endfunction

  function automatic exp_t model(input logic [19:0] instr, input logic [19:0] pc, input logic we,
                                 input logic [3:0] rdw, input logic [19:0] resw);
    exp_t e;
    logic [3:0] op;
    logic signed [19:0] s;
    e   = '0;
    op  = instr[19:16];
    e.rd  = instr[15:12];
    e.rs1 = instr[11:8];
    e.rs2 = instr[7:4];
    e.rd1 = model_read(instr[11:8], we, rdw, resw);
    e.rd2 = model_read(instr[7:4], we, rdw, resw);
    e.pc  = pc;
    e.pc4 = pc + 20'd4;
    e.illegal = (op > 4'd6) || (op == 4'd1 && instr[3]);
    if (op == 4'd1 && !instr[3]) begin
      e.reg_write   = 1'b1;
      e.alu_control = (instr[2:0] > 3'd5) ? 3'd0 : instr[2:0];
    end else if (op == 4'd2 || op == 4'd3) begin
      e.reg_write  = 1'b1;
      e.alu_src    = 1'b1;
      e.result_src = (op == 4'd3) ? 2'b01 : 2'b00;
      s = $signed(instr[7:0]);
      e.imm = s;
      e.imm_chk = 1'b1;
    end else if (op == 4'd4) begin
      e.mem_write = 1'b1;
      e.alu_src   = 1'b1;
      s = $signed({instr[15:12], instr[3:0]});
      e.imm = s;
      e.imm_chk = 1'b1;
    end else if (op == 4'd5) begin
      e.branch      = 1'b1;
      e.alu_control = 3'd1;
      s = $signed({instr[15:12], instr[3:0]});
      e.imm = s * 4;
      e.imm_chk = 1'b1;
    end else if (op == 4'd6) begin
      e.jump       = 1'b1;
      e.reg_write  = 1'b1;
      e.result_src = 2'b10;
      s = $signed(instr[11:0]);
      e.imm = s * 4;
      e.imm_chk = 1'b1;
    end
    return e;
  endfunction

  task automatic compare_out(input string ph);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val({ph, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check_val({ph, "_RegWriteE"}, RegWriteE, e.reg_write);
    check_val({ph, "_ResultSrcE"}, ResultSrcE, e.result_src);
    check_val({ph, "_MemWriteE"}, MemWriteE, e.mem_write);
    check_val({ph, "_JumpE"}, JumpE, e.jump);
    check_val({ph, "_BranchE"}, BranchE, e.branch);
    check_val({ph, "_ALUControlE"}, ALUControlE, e.alu_control);
    check_val({ph, "_ALUSrcE"}, ALUSrcE, e.alu_src);
    check_val({ph, "_RD1E"}, RD1E, e.rd1);
    check_val({ph, "_RD2E"}, RD2E, e.rd2);
    if (e.imm_chk) check_val({ph, "_ImmExtE"}, ImmExtE, e.imm);
    check_val({ph, "_PCE"}, PCE, e.pc);
    check_val({ph, "_PCPlus4E"}, PCPlus4E, e.pc4);
    check_val({ph, "_RdE"}, RdE, e.rd);
    check_val({ph, "_Rs1E"}, Rs1E, e.rs1);
    check_val({ph, "_Rs2E"}, Rs2E, e.rs2);
`ifdef DECODE_ILLEGAL_TRAP_EN
    check_val({ph, "_IllegalE"}, IllegalE, e.illegal);
`endif
    $display("txn %s instr=%05h RegWriteE=%0b ALUControlE=%0d RD1E=%05h ImmExtE=%05h RdE=%0d",
             ph, InstrD, RegWriteE, ALUControlE, RD1E, ImmExtE, RdE);
  endtask

  // One decode cycle: drive at negedge, compare 1 ns after the capturing edge.
  task automatic drive(input string ph, input logic [19:0] instr, input logic we,
                       input logic [3:0] rdw, input logic [19:0] resw,
                       input logic flush, input logic stall);
    exp_t e;
    InstrD = instr; PCD = pc_ctr; PCPlus4D = pc_ctr + 20'd4;
    RegWriteW = we; RdW = rdw; ResultW = resw; FlushE = flush; StallE = stall;
    if (flush)      e = zero_exp();
    else if (stall) e = last_exp;
    else            e = model(instr, pc_ctr, we, rdw, resw);
    last_exp = e;
    sb_q.push_back(e);
    @(posedge clk);
    if (we && rdw != 4'd0) mregs[rdw] = resw;
    pc_ctr = pc_ctr + 20'd4;
    #1;
    compare_out(ph);
    @(negedge clk);
    RegWriteW = 1'b0; FlushE = 1'b0; StallE = 1'b0;
  endtask

  initial begin
    rst = 1'b1; InstrD = '0; PCD = '0; PCPlus4D = '0;
    RegWriteW = 1'b0; RdW = '0; ResultW = '0; FlushE = 1'b0; StallE = 1'b0;
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    last_exp = zero_exp();

    repeat (2) @(negedge clk);
    sb_q.push_back(zero_exp());
    compare_out("rst_init");
    rst = 1'b0;

    drive("bypass", 20'h15330, 1'b1, 4'd3, 20'hABCDE, 1'b0, 1'b0);
    check_val("bypass_RD1E", RD1E, 20'hABCDE);
    check_val("bypass_RD2E", RD2E, 20'hABCDE);
    check_val("bypass_RdE", RdE, 4'd5);
    check_val("bypass_RegWriteE", RegWriteE, 1'b1);
    check_val("bypass_ALUControlE", ALUControlE, 3'b000);

    drive("read_x3", 20'h16330, 1'b0, 4'd0, 20'd0, 1'b0, 1'b0);
    check_val("read_x3_RD1E", RD1E, 20'hABCDE);

    drive("x0_bypass", 20'h17000, 1'b1, 4'd0, 20'hFFFFF, 1'b0, 1'b0);
    check_val("x0_bypass_RD1E", RD1E, 20'h00000);
    drive("x0_read", 20'h17000, 1'b0, 4'd0, 20'd0, 1'b0, 1'b0);
    check_val("x0_read_RD1E", RD1E, 20'h00000);

    drive("addi", 20'h221FF, 1'b0, 4'd0, 20'd0, 1'b0, 1'b0);
    check_val("addi_ImmExtE", ImmExtE, 20'hFFFFF);
    check_val("addi_ALUSrcE", ALUSrcE, 1'b1);

    drive("sub", 20'h1A121, 1'b1, 4'd1, 20'h00123, 1'b0, 1'b0);
    check_val("sub_RD1E", RD1E, 20'h00123);
    check_val("sub_ALUControlE", ALUControlE, 3'b001);

    drive("beq", 20'h5F128, 1'b0, 4'd0, 20'd0, 1'b0, 1'b0);
    check_val("beq_ImmExtE", ImmExtE, 20'hFFFE0);
    check_val("beq_BranchE", BranchE, 1'b1);
    check_val("beq_ALUControlE", ALUControlE, 3'b001);

    drive("store", 20'h43125, 1'b0, 4'd0, 20'd0, 1'b0, 1'b0);
    check_val("store_ImmExtE", ImmExtE, 20'h00035);
    check_val("store_MemWriteE", MemWriteE, 1'b1);

    drive("jal", 20'h65800, 1'b0, 4'd0, 20'd0, 1'b0, 1'b0);
    check_val("jal_ImmExtE", ImmExtE, 20'hFE000);
    check_val("jal_ResultSrcE", ResultSrcE, 2'b10);

    drive("ralu_f6", 20'h12116, 1'b0, 4'd0, 20'd0, 1'b0, 1'b0);
    check_val("ralu_f6_ALUControlE", ALUControlE, 3'b000);

    drive("load_flush", 20'h34110, 1'b0, 4'd0, 20'd0, 1'b1, 1'b0);
    check_val("load_flush_RegWriteE", RegWriteE, 1'b0);
    check_val("load_flush_ResultSrcE", ResultSrcE, 2'b00);

    drive("load", 20'h34110, 1'b0, 4'd0, 20'd0, 1'b0, 1'b0);
    check_val("load_ResultSrcE", ResultSrcE, 2'b01);

    for (int k = 0; k < 2; k++) begin
      drive("stall", 20'h221FF, 1'b0, 4'd0, 20'd0, 1'b0, 1'b1);
      check_val("stall_ResultSrcE", ResultSrcE, 2'b01);
      check_val("stall_ImmExtE", ImmExtE, 20'h00010);
    end

    drive("flush_stall", 20'h34110, 1'b0, 4'd0, 20'd0, 1'b1, 1'b1);
    check_val("flush_stall_RegWriteE", RegWriteE, 1'b0);
    check_val("flush_stall_ResultSrcE", ResultSrcE, 2'b00);

    drive("illegal_op", 20'h91234, 1'b0, 4'd0, 20'd0, 1'b0, 1'b0);
    check_val("illegal_op_RegWriteE", RegWriteE, 1'b0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    check_val("illegal_op_IllegalE", IllegalE, 1'b1);
`endif
    drive("illegal_funct", 20'h12118, 1'b0, 4'd0, 20'd0, 1'b0, 1'b0);
    check_val("illegal_funct_RegWriteE", RegWriteE, 1'b0);

    for (int k = 0; k < 40; k++) begin
      drive("rand", 20'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            20'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
    end

    // Asynchronous reset mid-stream with a coinciding writeback to x3.
    InstrD = 20'h12340; RegWriteW = 1'b1; RdW = 4'd3; ResultW = 20'h55555;
    rst = 1'b1;
    #1;
    sb_q.push_back(zero_exp());
    compare_out("rst_async");
    @(posedge clk);
    #1;
    sb_q.push_back(zero_exp());
    compare_out("rst_held");
    @(negedge clk);
    rst = 1'b0; RegWriteW = 1'b0;
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    last_exp = zero_exp();

    drive("post_rst", 20'h15330, 1'b0, 4'd0, 20'd0, 1'b0, 1'b0);
    check_val("post_rst_RD1E", RD1E, 20'h00000);
    drive("post_rst_x1", 20'h1A121, 1'b0, 4'd0, 20'd0, 1'b0, 1'b0);
    check_val("post_rst_x1_RD1E", RD1E, 20'h00000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
